// File: rtl/branch_checkpoint_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_checkpoint_writer_if
//  Brief    : Bundle between the rename stage / branch unit (master) and the
//             branch checkpoint writer (slave). The checkpoint state outputs
//             feed the branch-state consumers directly.
//  Revision : 1.0  initial release
// ============================================================================
interface branch_checkpoint_writer_if #(
    parameter int BRANCH_NUM       = 4,
    parameter int REG_NUM          = 32,
    parameter int PHYS_REG_NUM     = 64,
    parameter int ACTIVE_LIST_SIZE = 64
);
    localparam int BN_IDX = $clog2(BRANCH_NUM);
    localparam int AR_IDX = $clog2(REG_NUM);
    localparam int PR_IDX = $clog2(PHYS_REG_NUM);
    localparam int AL_IDX = $clog2(ACTIVE_LIST_SIZE);

    // Checkpoint allocation at rename
    logic                               alloc_req;
    logic                               alloc_ready;
    logic [AL_IDX-1:0]                  alloc_id;
    logic [PR_IDX-1:0]                  alloc_free_head;
    logic [REG_NUM*PR_IDX-1:0]          alloc_map;

    // Delay-slot fold-in
    logic                               ds_req;
    logic                               ds_dest_we;
    logic [AR_IDX-1:0]                  ds_arch;
    logic [PR_IDX-1:0]                  ds_phys;
    logic [PR_IDX-1:0]                  ds_free_head;

    // Branch resolution and misprediction recovery
    logic                               resolve_ok;
    logic [AL_IDX-1:0]                  resolve_id;
    logic                               recover_en;
    logic [BRANCH_NUM-1:0]              recover_valid;
    logic [BN_IDX-1:0]                  recover_wp;

    // Checkpoint state
    logic [BRANCH_NUM-1:0]              valid;
    logic [BN_IDX-1:0]                  write_pointer;
    logic [BRANCH_NUM*AL_IDX-1:0]       branch_id;
    logic [BRANCH_NUM*PR_IDX-1:0]       free_head;
    logic [BRANCH_NUM*REG_NUM*PR_IDX-1:0] rename_buf;
    logic [BRANCH_NUM-1:0]              ds_valid;
    logic [BN_IDX:0]                    live_count;

    modport master (
        output alloc_req, alloc_id, alloc_free_head, alloc_map,
        output ds_req, ds_dest_we, ds_arch, ds_phys, ds_free_head,
        output resolve_ok, resolve_id, recover_en, recover_valid, recover_wp,
        input  alloc_ready, valid, write_pointer, branch_id, free_head,
        input  rename_buf, ds_valid, live_count
    );

    modport slave (
        input  alloc_req, alloc_id, alloc_free_head, alloc_map,
        input  ds_req, ds_dest_we, ds_arch, ds_phys, ds_free_head,
        input  resolve_ok, resolve_id, recover_en, recover_valid, recover_wp,
        output alloc_ready, valid, write_pointer, branch_id, free_head,
        output rename_buf, ds_valid, live_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_checkpoint_writer.sv
`default_nettype none
// ============================================================================
//  Module   : branch_checkpoint_writer
//  Brief    : Creates and retires branch checkpoints (branch id, free-list
//             head, full rename map) used by misprediction recovery. The
//             delay-slot rename is folded into the most recent checkpoint.
//  Revision : 1.0  initial release
// ============================================================================
module branch_checkpoint_writer #(
    parameter int BRANCH_NUM       = 4,
    parameter int REG_NUM          = 32,
    parameter int PHYS_REG_NUM     = 64,
    parameter int ACTIVE_LIST_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    branch_checkpoint_writer_if.slave     bus
);
    localparam int BN_IDX = $clog2(BRANCH_NUM);
    localparam int PR_IDX = $clog2(PHYS_REG_NUM);
    localparam int AL_IDX = $clog2(ACTIVE_LIST_SIZE);
    localparam int MAP_W  = REG_NUM * PR_IDX;

    localparam logic [BN_IDX-1:0] c_wp_one = BN_IDX'(1);

    // ------------------------------------------------------------------
    // Registered checkpoint state
    // ------------------------------------------------------------------
    logic [BRANCH_NUM-1:0] r_valid;
    logic [BRANCH_NUM-1:0] r_ds_valid;
    logic [BN_IDX-1:0]     r_wp;
    logic [AL_IDX-1:0]     r_branch_id  [BRANCH_NUM];
    logic [PR_IDX-1:0]     r_free_head  [BRANCH_NUM];
    logic [MAP_W-1:0]      r_rename_buf [BRANCH_NUM];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  w_alloc_ready;
    logic                  w_alloc_fire;
    logic [BN_IDX-1:0]     w_ds_slot;
    logic                  w_ds_fire;
    logic [BRANCH_NUM-1:0] w_alloc_onehot;
    logic [BRANCH_NUM-1:0] w_ds_onehot;
    logic [BRANCH_NUM-1:0] w_resolve_clear;
    logic [BRANCH_NUM-1:0] w_valid_nxt;
    logic [BN_IDX-1:0]     w_wp_nxt;
    logic [BN_IDX:0]       w_live_count;

    // Allocation never skips a stale slot: it simply waits for it to free up.
    assign w_alloc_ready = ~r_valid[r_wp];
    assign w_alloc_fire  = bus.alloc_req & w_alloc_ready & ~bus.recover_en;

    // The delay slot belongs to the branch most recently checkpointed, which
    // sits one behind the write pointer as seen before this cycle's update.
    assign w_ds_slot = r_wp - c_wp_one;
    assign w_ds_fire = bus.ds_req & r_valid[w_ds_slot] & ~bus.recover_en;

    // One-hot slot selects for the allocate and delay-slot writes
    always_comb begin
        w_alloc_onehot = '0;
        w_ds_onehot    = '0;
        if (w_alloc_fire) begin
            w_alloc_onehot[r_wp] = 1'b1;
        end
        if (w_ds_fire) begin
            w_ds_onehot[w_ds_slot] = 1'b1;
        end
    end

    // Every live slot whose branch id matches a correct resolution retires
    always_comb begin
        w_resolve_clear = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            w_resolve_clear[i] = bus.resolve_ok & r_valid[i] &
                                 (r_branch_id[i] == bus.resolve_id);
        end
    end

    // Next valid mask / write pointer; recovery overrides the front end
    always_comb begin
        w_valid_nxt = r_valid;
        w_wp_nxt    = r_wp;
        if (bus.recover_en) begin
            w_valid_nxt = bus.recover_valid & ~w_resolve_clear;
            w_wp_nxt    = bus.recover_wp;
        end else begin
            w_valid_nxt = (r_valid & ~w_resolve_clear) | w_alloc_onehot;
            if (w_alloc_fire) begin
                w_wp_nxt = r_wp + c_wp_one;
            end
        end
    end

    // Valid mask and write pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_wp    <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_wp    <= w_wp_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot checkpoint payload. Invalidated slots keep their contents.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < BRANCH_NUM; g++) begin : g_slot
            // Capture the branch checkpoint, then fold in its delay slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ds_valid[g]   <= 1'b0;
                    r_branch_id[g]  <= '0;
                    r_free_head[g]  <= '0;
                    r_rename_buf[g] <= '0;
                end else begin
                    if (w_alloc_onehot[g]) begin
                        r_ds_valid[g]   <= 1'b0;
                        r_branch_id[g]  <= bus.alloc_id;
                        r_free_head[g]  <= bus.alloc_free_head;
                        r_rename_buf[g] <= bus.alloc_map;
                    end
                    if (w_ds_onehot[g]) begin
                        r_ds_valid[g]  <= 1'b1;
                        r_free_head[g] <= bus.ds_free_head;
                        if (bus.ds_dest_we) begin
                            r_rename_buf[g][bus.ds_arch*PR_IDX +: PR_IDX] <= bus.ds_phys;
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Population count of live checkpoints
    always_comb begin
        w_live_count = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            w_live_count = w_live_count + (BN_IDX+1)'(r_valid[i]);
        end
    end

    logic [BRANCH_NUM*AL_IDX-1:0] w_branch_id_flat;
    logic [BRANCH_NUM*PR_IDX-1:0] w_free_head_flat;
    logic [BRANCH_NUM*MAP_W-1:0]  w_rename_flat;

    // Flatten per-slot payload, slot i in the i-th field
    always_comb begin
        w_branch_id_flat = '0;
        w_free_head_flat = '0;
        w_rename_flat    = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            w_branch_id_flat[i*AL_IDX +: AL_IDX] = r_branch_id[i];
            w_free_head_flat[i*PR_IDX +: PR_IDX] = r_free_head[i];
            w_rename_flat[i*MAP_W +: MAP_W]      = r_rename_buf[i];
        end
    end

    assign bus.alloc_ready   = w_alloc_ready;
    assign bus.valid         = r_valid;
    assign bus.write_pointer = r_wp;
    assign bus.branch_id     = w_branch_id_flat;
    assign bus.free_head     = w_free_head_flat;
    assign bus.rename_buf    = w_rename_flat;
    assign bus.ds_valid      = r_ds_valid;
    assign bus.live_count    = w_live_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_checkpoint_writer
//  Brief    : Directed and random stimulus for branch_checkpoint_writer,
//             compared every cycle against a slot-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_checkpoint_writer;
    localparam int BN   = 4;
    localparam int NREG = 32;
    localparam int PRW  = 6;
    localparam int ALW  = 6;
    localparam int MAPW = NREG * PRW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_checkpoint_writer_if bus ();

    branch_checkpoint_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: plain arrays of slots
    bit           m_valid [BN];
    bit           m_dsv   [BN];
    int           m_wp;
    logic [5:0]   m_bid   [BN];
    logic [5:0]   m_fh    [BN];
    logic [5:0]   m_map   [BN][NREG];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wp = 0;
        for (int i = 0; i < BN; i++) begin
            m_valid[i] = 0;
            m_dsv[i]   = 0;
            m_bid[i]   = '0;
            m_fh[i]    = '0;
            for (int r = 0; r < NREG; r++) m_map[i][r] = '0;
        end
    endtask

    // One clock of the behaviour, evaluated from the current bus inputs
    task automatic model_step();
        bit clr [BN];
        bit rdy;
        int p;
        rdy = !m_valid[m_wp];
        p   = (m_wp + BN - 1) % BN;
        for (int i = 0; i < BN; i++)
            clr[i] = bus.resolve_ok && m_valid[i] && (m_bid[i] == bus.resolve_id);
        if (bus.recover_en) begin
            for (int i = 0; i < BN; i++) m_valid[i] = bus.recover_valid[i] && !clr[i];
            m_wp = int'(bus.recover_wp);
        end else begin
            if (bus.ds_req && m_valid[p]) begin
                m_dsv[p] = 1;
                m_fh[p]  = bus.ds_free_head;
                if (bus.ds_dest_we) m_map[p][bus.ds_arch] = bus.ds_phys;
            end
            for (int i = 0; i < BN; i++) if (clr[i]) m_valid[i] = 0;
            if (bus.alloc_req && rdy) begin
                m_valid[m_wp] = 1;
                m_dsv[m_wp]   = 0;
                m_bid[m_wp]   = bus.alloc_id;
                m_fh[m_wp]    = bus.alloc_free_head;
                for (int r = 0; r < NREG; r++) m_map[m_wp][r] = bus.alloc_map[r*PRW +: PRW];
                m_wp = (m_wp + 1) % BN;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [BN-1:0]   ev, ed;
        logic [MAPW-1:0] em;
        int              cnt;
        cnt = 0;
        for (int i = 0; i < BN; i++) begin
            ev[i] = m_valid[i];
            ed[i] = m_dsv[i];
            cnt += int'(m_valid[i]);
        end
        chk({tag, ".valid"},       256'(bus.valid),         256'(ev));
        chk({tag, ".wp"},          256'(bus.write_pointer), 256'(m_wp));
        chk({tag, ".live_count"},  256'(bus.live_count),    256'(cnt));
        chk({tag, ".alloc_ready"}, 256'(bus.alloc_ready),   256'(!m_valid[m_wp]));
        chk({tag, ".ds_valid"},    256'(bus.ds_valid),      256'(ed));
        for (int i = 0; i < BN; i++) begin
            for (int r = 0; r < NREG; r++) em[r*PRW +: PRW] = m_map[i][r];
            chk($sformatf("%s.bid%0d", tag, i),  256'(bus.branch_id[i*ALW +: ALW]),   256'(m_bid[i]));
            chk($sformatf("%s.fh%0d", tag, i),   256'(bus.free_head[i*PRW +: PRW]),   256'(m_fh[i]));
            chk($sformatf("%s.map%0d", tag, i),  256'(bus.rename_buf[i*MAPW +: MAPW]), 256'(em));
        end
    endtask

    task automatic idle();
        bus.alloc_req       = 1'b0;
        bus.alloc_id        = '0;
        bus.alloc_free_head = '0;
        bus.alloc_map       = '0;
        bus.ds_req          = 1'b0;
        bus.ds_dest_we      = 1'b0;
        bus.ds_arch         = '0;
        bus.ds_phys         = '0;
        bus.ds_free_head    = '0;
        bus.resolve_ok      = 1'b0;
        bus.resolve_id      = '0;
        bus.recover_en      = 1'b0;
        bus.recover_valid   = '0;
        bus.recover_wp      = '0;
    endtask

    // Inputs are set at the falling edge; state is checked one falling edge later
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
        idle();
    endtask

    task automatic set_alloc(input logic [5:0] id);
        bus.alloc_req       = 1'b1;
        bus.alloc_id        = id;
        bus.alloc_free_head = 6'($urandom);
        for (int r = 0; r < NREG; r++) bus.alloc_map[r*PRW +: PRW] = 6'($urandom);
    endtask

    task automatic do_alloc(input logic [5:0] id, input string tag);
        set_alloc(id);
        step(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        model_reset();
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of operation with three live slots
        do_alloc(6'd1, "t1.a0");
        do_alloc(6'd2, "t1.a1");
        do_alloc(6'd3, "t1.a2");
        chk("t1.live3", 256'(bus.live_count), 256'(3));
        do_reset("t1.rst");
        chk("t1.valid0", 256'(bus.valid), 256'(0));

        // Fill all four slots, then a further request must stall
        do_alloc(6'd5, "t2.a5");
        do_alloc(6'd6, "t2.a6");
        do_alloc(6'd7, "t2.a7");
        do_alloc(6'd8, "t2.a8");
        chk("t2.full",  256'(bus.valid),       256'(4'hF));
        chk("t2.ready", 256'(bus.alloc_ready), 256'(0));
        do_alloc(6'd9, "t2.stall");
        chk("t2.wp", 256'(bus.write_pointer), 256'(0));

        // Resolve slot 0's branch, the next allocation reuses slot 0
        bus.resolve_ok = 1'b1;
        bus.resolve_id = 6'd5;
        step("t4.res");
        chk("t4.ready", 256'(bus.alloc_ready), 256'(1));
        do_alloc(6'd9, "t4.a9");
        chk("t4.bid0", 256'(bus.branch_id[5:0]), 256'(9));

        // Delay slot folds into the last checkpoint
        do_reset("t3.rst");
        do_alloc(6'd5, "t3.a5");
        bus.ds_req       = 1'b1;
        bus.ds_dest_we   = 1'b1;
        bus.ds_arch      = 5'd3;
        bus.ds_phys      = 6'd40;
        bus.ds_free_head = 6'd12;
        step("t3.ds");
        chk("t3.dsv0",  256'(bus.ds_valid[0]),        256'(1));
        chk("t3.map03", 256'(bus.rename_buf[23:18]),  256'(40));
        chk("t3.fh0",   256'(bus.free_head[5:0]),     256'(12));

        // Recovery wins over a simultaneous allocation
        do_reset("t5.rst");
        do_alloc(6'd20, "t5.a0");
        do_alloc(6'd21, "t5.a1");
        do_alloc(6'd22, "t5.a2");
        set_alloc(6'd23);
        bus.recover_en    = 1'b1;
        bus.recover_valid = 4'b0001;
        bus.recover_wp    = 2'd1;
        step("t5.rec");
        chk("t5.valid", 256'(bus.valid),         256'(4'b0001));
        chk("t5.wp",    256'(bus.write_pointer), 256'(1));

        // Recovery combined with a same-cycle correct resolution
        do_reset("t6.rst");
        do_alloc(6'd10, "t6.a0");
        do_alloc(6'd11, "t6.a1");
        bus.recover_en    = 1'b1;
        bus.recover_valid = 4'b0011;
        bus.recover_wp    = 2'd2;
        bus.resolve_ok    = 1'b1;
        bus.resolve_id    = 6'd10;
        step("t6.rec");
        chk("t6.valid", 256'(bus.valid),         256'(4'b0010));
        chk("t6.wp",    256'(bus.write_pointer), 256'(2));

        // Random traffic against the model
        do_reset("rnd.rst");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(1, 0) == 1) set_alloc(6'($urandom_range(7, 0)));
            bus.ds_req        = ($urandom_range(2, 0) == 0);
            bus.ds_dest_we    = 1'($urandom);
            bus.ds_arch       = 5'($urandom);
            bus.ds_phys       = 6'($urandom);
            bus.ds_free_head  = 6'($urandom);
            bus.resolve_ok    = ($urandom_range(2, 0) == 0);
            bus.resolve_id    = 6'($urandom_range(7, 0));
            bus.recover_en    = ($urandom_range(15, 0) == 0);
            bus.recover_valid = 4'($urandom);
            bus.recover_wp    = 2'($urandom);
            step($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
